// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer/count width function and error-flag bit indices.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    // Positions of the sticky error flags inside the packed error register
    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UDF_BIT = 1;
    localparam int ERR_W       = 2;

    // Ceiling log2, never below 1 so that a degenerate size still yields a usable bus
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; (1 << i) < value; i++) begin
            r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_n_mem.sv
// Storage array for fifo_n_cnt: width x depth, one write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after we_i; read is combinational.
// Backpressure: none; the caller guarantees writes only target free slots. Reset of contents under FIFO_N_CNT_RESET_HEAD_EN.
module fifo_n_mem
    import fifo_pkg::*;
#(
    parameter int width = 1,
    parameter int depth = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [clog2(depth)-1:0]   waddr_i,
    input  logic [width-1:0]          wdata_i,
    input  logic [clog2(depth)-1:0]   raddr_i,
    output logic [width-1:0]          rdata_o
);

    logic [width-1:0] mem_q [depth];

`ifdef FIFO_N_CNT_RESET_HEAD_EN
    // Write port; reset clears every entry so the head reads zero afterwards
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
`else
    // Storage has no reset in this build; the reset input is intentionally left unused
    logic unused_rst;
    assign unused_rst = rst_i;

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
`endif

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_n_cnt.sv
// Counted FIFO of any depth (non power of two allowed) with sticky overflow/underflow flags; FIFO_N_CNT_RESET_HEAD_EN also resets storage.
// Latency: enqueue visible on EMPTY_N/D_OUT one cycle later, no bypass; D_OUT is combinational from the head slot.
// Backpressure: FULL_N/EMPTY_N come from the registered count only; enqueue when full is dropped (guarded=0 lets ENQ+DEQ through).
module fifo_n_cnt
    import fifo_pkg::*;
#(
    parameter int width    = 1,
    parameter int depth    = 4,
    parameter int guarded  = 1,
    parameter int af_level = depth - 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [width-1:0]             D_IN,
    input  logic                         ENQ,
    input  logic                         DEQ,
    input  logic                         CLR,
    output logic [width-1:0]             D_OUT,
    output logic                         FULL_N,
    output logic                         EMPTY_N,
    output logic                         ALMOST_FULL_N,
    output logic [clog2(depth+1)-1:0]    COUNT,
    output logic                         ERR_OVF,
    output logic                         ERR_UDF
);

    localparam int PW = clog2(depth);
    localparam int CW = clog2(depth + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(depth);
    localparam logic [CW-1:0] CNT_AF   = CW'(af_level);

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic is_full;
    logic is_empty;
    logic enq_ok;
    logic deq_ok;
    logic mem_we;

    // Pointers wrap at depth-1 rather than at a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign is_full  = (count_q == CNT_FULL);
    assign is_empty = (count_q == '0);

    // Acceptance, error detection and next-state for pointers, count and flags
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q;

        deq_ok = DEQ && !is_empty;
        // The slot freed by a same-cycle dequeue can be reused only in unguarded mode
        enq_ok = ENQ && (!is_full || ((guarded == 0) && DEQ));

        if (CLR) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            err_d    = '0;
        end else begin
            if (enq_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (deq_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (enq_ok && !deq_ok) begin
                count_d = count_q + 1'b1;
            end else if (deq_ok && !enq_ok) begin
                count_d = count_q - 1'b1;
            end
            if (ENQ && !enq_ok) begin
                err_d[ERR_OVF_BIT] = 1'b1;
            end
            if (DEQ && is_empty) begin
                err_d[ERR_UDF_BIT] = 1'b1;
            end
        end
    end

    // Flush and reset both suppress the storage write
    assign mem_we = enq_ok && !CLR && !RST;

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    fifo_n_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (D_IN),
        .raddr_i (rd_ptr_q),
        .rdata_o (D_OUT)
    );

    assign COUNT         = count_q;
    assign FULL_N        = !is_full;
    assign EMPTY_N       = !is_empty;
    assign ALMOST_FULL_N = !(count_q >= CNT_AF);
    assign ERR_OVF       = err_q[ERR_OVF_BIT];
    assign ERR_UDF       = err_q[ERR_UDF_BIT];

endmodule

// File: doc/fifo_n_cnt.md
FIFO_N_CNT -- requirements
Module: fifo_n_cnt

Interface
REQ-001 SHALL have parameter width, default 1: data width in bits, minimum 1.
REQ-002 SHALL have parameter depth, default 4: entry count, minimum 2, any integer (not only powers of 2).
REQ-003 SHALL have parameter guarded, default 1: 1 = ENQ while full is dropped even with DEQ; 0 = ENQ+DEQ while full is legal.
REQ-004 SHALL have parameter af_level, default depth-1: ALMOST_FULL_N deasserts when COUNT >= af_level, legal range 1..depth.
REQ-005 SHALL have the following ports. Clock and reset: one clock; reset is synchronous and active-high.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- D_IN  input  width  enqueue data.
- ENQ  input  1  enqueue request.
- DEQ  input  1  dequeue request.
- CLR  input  1  synchronous flush.
- D_OUT  output  width  head entry.
- FULL_N  output  1  1 = space available.
- EMPTY_N  output  1  1 = data available.
- ALMOST_FULL_N  output  1  0 when COUNT >= af_level.
- COUNT  output  $clog2(depth+1)  occupancy.
- ERR_OVF  output  1  sticky; set by a dropped enqueue.
- ERR_UDF  output  1  sticky; set by a dequeue while empty.

Function
REQ-006 SHALL store entries in a circular buffer addressed by rd_ptr and wr_ptr, each $clog2(depth) bits, each wrapping from depth-1 to 0.
REQ-007 SHALL drive D_OUT combinationally from mem[rd_ptr]; D_OUT is undefined when EMPTY_N=0.
REQ-008 SHALL accept an enqueue when ENQ=1 and the FIFO is not full: write mem[wr_ptr], advance wr_ptr. Enqueue-to-EMPTY_N latency is 1 cycle; no bypass.
REQ-009 SHALL accept a dequeue when DEQ=1 and the FIFO is not empty: advance rd_ptr.
REQ-010 SHALL update COUNT as follows: +1 on accepted enqueue only, -1 on accepted dequeue only, unchanged when both are accepted; COUNT never leaves 0..depth.
REQ-011 SHALL derive FULL_N, EMPTY_N and ALMOST_FULL_N from registered COUNT and SHALL NOT have a combinational path from ENQ or DEQ to them.
REQ-012 SHALL handle ENQ+DEQ while empty as follows: enqueue accepted, dequeue ignored, ERR_UDF set, COUNT becomes 1.
REQ-013 SHALL handle ENQ+DEQ while full as follows: with guarded=0, both accepted and COUNT stays at depth; with guarded=1, dequeue accepted, enqueue dropped and ERR_OVF set.
REQ-014 SHALL handle ENQ alone while full as follows: data dropped, ERR_OVF set, no state change.
REQ-015 SHALL make ERR_OVF and ERR_UDF sticky, cleared only by RST or CLR.
REQ-016 SHALL on CLR zero both pointers, COUNT and both error flags, take priority over same-cycle ENQ and DEQ, and leave memory contents unchanged.

Reset
REQ-017 SHALL on RST=1 set COUNT=0, EMPTY_N=0, FULL_N=1, ALMOST_FULL_N=1 (0 if af_level would be met at 0 entries; that cannot happen since af_level >= 1), ERR_OVF=0, ERR_UDF=0 and rd_ptr=wr_ptr=0.
REQ-018 SHALL ignore ENQ, DEQ and CLR while RST=1; reset mid-traffic discards all entries.

Configuration
REQ-019 SHALL reset the storage array on the FIFO_N_CNT_RESET_HEAD_EN macro as follows: when defined, RST also clears every mem entry to 0, so D_OUT reads 0 after reset; when undefined, the storage array has no reset.

Structure
REQ-020 SHALL take the pointer/count width helper (clog2 function) and the error-flag bit index constants from shared package fifo_pkg.
REQ-021 SHALL place storage in sub-module fifo_n_mem (width x depth array, one write port, one asynchronous read port, optional reset per REQ-019); pointer, count and flag logic stays in fifo_n_cnt.

Verification
REQ-022 SHALL be covered by a bench using width=8, depth=3, af_level=2, covering at least the following directed scenarios:
- Fill/drain with non-power-of-2 wrap: enqueue 0x11, 0x22, 0x33 -> COUNT=3, FULL_N=0, ALMOST_FULL_N=0; dequeue all -> D_OUT 0x11, 0x22, 0x33 in order; repeat 3 times -> order preserved across pointer wrap 2->0.
- Simultaneous ENQ+DEQ at COUNT=1: COUNT stays 1 for 5 cycles; data order preserved.
- Full plus ENQ+DEQ, guarded=1: ERR_OVF=1, COUNT=2. Same stimulus with guarded=0: COUNT=3, ERR_OVF=0, new data appears at the tail.
- DEQ while empty: ERR_UDF=1 next cycle and stays set; then CLR -> ERR_UDF=0, COUNT=0.
- CLR with ENQ in the same cycle at COUNT=2: COUNT=0, EMPTY_N=0 next cycle.
- RST asserted at COUNT=2: all outputs take reset values next cycle; with FIFO_N_CNT_RESET_HEAD_EN defined, D_OUT=0x00.
